// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the 256-cycle PWM link (transmitter and capture).
//   PWM_PERIOD      frame length in clk cycles (count wraps 0..PERIOD-1)
//   PWM_SAMPLE_W    sample width; wide enough to hold the value PERIOD
//   pwm_cap_state_t capture FSM states
//   cnt_width()     width of a 0..period-1 counter
// ----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned PWM_PERIOD   = 256;
    localparam int unsigned PWM_SAMPLE_W = 9;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } pwm_cap_state_t;

    // Width of a counter spanning 0..period-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// ----------------------------------------------------------------------------
// pwm_sync_edge
// Brings the asynchronous PWM input into the clk domain and flags rising
// edges of the synchronized level.
//   clk    in   system clock
//   rst    in   synchronous active-high reset; clears every flop to 0
//   pwm_i  in   asynchronous PWM input
//   s      out  synchronized input (SYNC_STAGES cycles behind pwm_i)
//   rise   out  s & ~s_d, high for the first cycle s is high
// ----------------------------------------------------------------------------
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q[0] <= pwm_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        s    = sync_q[SYNC_STAGES-1];
        rise = sync_q[SYNC_STAGES-1] & ~s_d;
    end

endmodule

// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture
// Receive end of the PWM link: aligns to frame starts (rising edges) and
// counts high cycles per PERIOD-cycle frame, reporting one sample per frame.
//   clk     in   system clock (same clock as the transmitter)
//   rst     in   synchronous active-high reset
//   enable  in   capture enable; low forces HUNT and silences ready/err
//   pwm_i   in   PWM input, asynchronous
//   sample  out  high-cycle count of the last completed frame (0..PERIOD)
//   ready   out  one-cycle strobe, sample updated this cycle
//   err     out  one-cycle strobe, rising edge seen at nonzero phase
//   locked  out  high while tracking frames
// ----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD      = PWM_PERIOD,
    parameter int unsigned SAMPLE_W    = PWM_SAMPLE_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_i,
    output logic [SAMPLE_W-1:0] sample,
    output logic                ready,
    output logic                err,
    output logic                locked
);

    localparam int unsigned CNT_W = cnt_width(PERIOD);

    localparam logic [CNT_W-1:0]    LAST_PHASE = CNT_W'(PERIOD - 1);
    localparam logic [SAMPLE_W-1:0] FULL_SCALE = SAMPLE_W'(PERIOD);

    logic s;
    logic rise;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .pwm_i (pwm_i),
        .s     (s),
        .rise  (rise)
    );

    pwm_cap_state_t      state;
    logic [CNT_W-1:0]    phase;
    logic [CNT_W-1:0]    idle;
    logic [SAMPLE_W-1:0] high_cnt;
    logic [SAMPLE_W-1:0] high_next;

    // Count including the current cycle; at most PERIOD, so no saturation.
    always_comb begin
        high_next = high_cnt + SAMPLE_W'(s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            phase    <= '0;
            idle     <= '0;
            high_cnt <= '0;
            sample   <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else if (!enable) begin
            // sample deliberately holds its last value
            state    <= HUNT;
            phase    <= '0;
            idle     <= '0;
            high_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                HUNT: begin
                    // Edge has priority over a coincident idle timeout.
                    if (rise) begin
                        // This cycle is phase 0 and its high level counts.
                        state    <= TRACK;
                        phase    <= CNT_W'(1);
                        high_cnt <= SAMPLE_W'(1);
                        idle     <= '0;
                        locked   <= 1'b1;
                    end else if (idle == LAST_PHASE) begin
                        // A whole frame without edges: constant level.
                        sample <= s ? FULL_SCALE : '0;
                        ready  <= 1'b1;
                        idle   <= '0;
                    end else begin
                        idle <= idle + CNT_W'(1);
                    end
                end

                TRACK: begin
                    locked <= 1'b1;
                    // An edge anywhere but phase 0 (including the last
                    // phase) drops the partial frame and re-aligns here.
                    if (rise && (phase != '0)) begin
                        err      <= 1'b1;
                        phase    <= CNT_W'(1);
                        high_cnt <= SAMPLE_W'(1);
                    end else if (phase == LAST_PHASE) begin
                        sample   <= high_next;
                        ready    <= 1'b1;
                        high_cnt <= '0;
                        phase    <= '0;
                    end else begin
                        high_cnt <= high_next;
                        phase    <= phase + CNT_W'(1);
                    end
                end

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule
